// File: rtl/vga_pattern_gen.sv
// Multi-mode VGA test-pattern generator: colour bars (optionally scrolling), checkerboard,
// gray ramp and solid colour, with syncs and data-enable delay-matched to the 2-stage colour path.
module vga_pattern_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int POS_W      = 10,
  parameter int COLOR_W    = 4,
  parameter int NUM_BARS   = 8,
  parameter int CHECK_LOG2 = 5,
  parameter int GRAD_SHIFT = 5,
  parameter int SCROLL_DIV = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [POS_W-1:0]     hpos,
  input  logic [POS_W-1:0]     vpos,
  input  logic                 display_on,
  input  logic                 hsync_in,
  input  logic                 vsync_in,
  input  logic [1:0]           mode_req,
  input  logic                 scroll_en,
  input  logic [3*COLOR_W-1:0] solid_rgb,
  output logic [COLOR_W-1:0]   VGA_R,
  output logic [COLOR_W-1:0]   VGA_G,
  output logic [COLOR_W-1:0]   VGA_B,
  output logic                 VGA_HS,
  output logic                 VGA_VS,
  output logic                 de_out,
  output logic                 frame_start
);

  localparam int BAR_W = H_ACTIVE / NUM_BARS;

  typedef enum logic [1:0] {
    MODE_BARS  = 2'd0,
    MODE_CHECK = 2'd1,
    MODE_RAMP  = 2'd2,
    MODE_SOLID = 2'd3
  } mode_t;

  mode_t                active_mode;
  mode_t                pix_mode;
  mode_t                s1_mode;
  logic [7:0]           frame_cnt;
  logic [7:0]           pix_frame;
  logic                 synced;
  logic                 is_fs;
  logic                 visible;
  logic [POS_W-1:0]     bar_cnt;
  logic [2:0]           bar_idx;
  logic [2:0]           offset;
  logic [2:0]           s1_offset;
  logic [2:0]           code;
  logic                 s1_hs;
  logic                 s1_vs;
  logic                 s1_de;
  logic                 s1_fs;
  logic                 s1_visible;
  logic                 s1_cell;
  logic [COLOR_W-1:0]   s1_gray;
  logic [3*COLOR_W-1:0] s1_solid;
  logic [3*COLOR_W-1:0] rgb_next;

  // The frame-start pixel already uses the newly requested mode and the advanced frame count,
  // so every pixel of a frame sees one consistent mode and scroll offset.
  always_comb begin
    is_fs     = (hpos == '0) && (vpos == '0);
    pix_mode  = is_fs ? mode_t'(mode_req) : active_mode;
    pix_frame = is_fs ? frame_cnt + 8'd1 : frame_cnt;
    offset    = scroll_en ? pix_frame[SCROLL_DIV +: 3] : 3'd0;
    visible   = display_on && (hpos < POS_W'(H_ACTIVE)) && (vpos < POS_W'(V_ACTIVE))
                && (synced || is_fs);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      active_mode <= MODE_BARS;
      frame_cnt   <= 8'd0;
      synced      <= 1'b0;
    end else if (is_fs) begin
      active_mode <= pix_mode;
      frame_cnt   <= pix_frame;
      synced      <= 1'b1;
    end
  end

  // After each edge the counter pair describes the pixel just registered into stage 1.
  always_ff @(posedge clk) begin
    if (reset || (hpos == '0)) begin
      bar_cnt <= '0;
      bar_idx <= 3'd0;
    end else if (hpos < POS_W'(H_ACTIVE)) begin
      if (bar_cnt == POS_W'(BAR_W - 1)) begin
        bar_cnt <= '0;
        bar_idx <= bar_idx + 3'd1;
      end else begin
        bar_cnt <= bar_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_hs      <= 1'b0;
      s1_vs      <= 1'b0;
      s1_de      <= 1'b0;
      s1_fs      <= 1'b0;
      s1_visible <= 1'b0;
      s1_mode    <= MODE_BARS;
      s1_offset  <= 3'd0;
      s1_cell    <= 1'b0;
      s1_gray    <= '0;
      s1_solid   <= '0;
    end else begin
      s1_hs      <= hsync_in;
      s1_vs      <= vsync_in;
      s1_de      <= display_on;
      s1_fs      <= is_fs;
      s1_visible <= visible;
      s1_mode    <= pix_mode;
      s1_offset  <= offset;
      s1_cell    <= hpos[CHECK_LOG2] ^ vpos[CHECK_LOG2];
      s1_gray    <= hpos[GRAD_SHIFT +: COLOR_W];
      s1_solid   <= solid_rgb;
    end
  end

  always_comb begin
    code     = bar_idx + s1_offset;
    rgb_next = '0;
    if (s1_visible) begin
      case (s1_mode)
        MODE_BARS:  rgb_next = {{COLOR_W{code[2]}}, {COLOR_W{code[1]}}, {COLOR_W{code[0]}}};
        MODE_CHECK: rgb_next = {(3*COLOR_W){s1_cell}};
        MODE_RAMP:  rgb_next = {3{s1_gray}};
        default:    rgb_next = s1_solid;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      VGA_R       <= '0;
      VGA_G       <= '0;
      VGA_B       <= '0;
      VGA_HS      <= 1'b0;
      VGA_VS      <= 1'b0;
      de_out      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      VGA_R       <= rgb_next[3*COLOR_W-1 -: COLOR_W];
      VGA_G       <= rgb_next[2*COLOR_W-1 -: COLOR_W];
      VGA_B       <= rgb_next[COLOR_W-1:0];
      VGA_HS      <= s1_hs;
      VGA_VS      <= s1_vs;
      de_out      <= s1_de;
      frame_start <= s1_fs;
    end
  end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Randomized bench for vga_pattern_gen: every cycle is compared with a behavioural pixel model
// that computes colours from screen coordinates with plain arithmetic, delayed by two clocks.
module tb_vga_pattern_gen;

  logic        clk;
  logic        reset;
  logic [9:0]  hpos;
  logic [9:0]  vpos;
  logic        display_on;
  logic        hsync_in;
  logic        vsync_in;
  logic [1:0]  mode_req;
  logic        scroll_en;
  logic [11:0] solid_rgb;
  logic [3:0]  VGA_R;
  logic [3:0]  VGA_G;
  logic [3:0]  VGA_B;
  logic        VGA_HS;
  logic        VGA_VS;
  logic        de_out;
  logic        frame_start;

  int          checks = 0;
  int          errors = 0;
  int          m_mode = 0;
  int          m_frames = 0;
  bit          m_synced = 0;
  logic [15:0] pipe1 = '0;
  logic [15:0] pipe2 = '0;
  logic [11:0] dut_rgb;
  int          frame_lines [7] = '{0, 1, 31, 32, 33, 479, 480};

  vga_pattern_gen dut (
    .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos), .display_on(display_on),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .mode_req(mode_req), .scroll_en(scroll_en),
    .solid_rgb(solid_rgb), .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B), .VGA_HS(VGA_HS),
    .VGA_VS(VGA_VS), .de_out(de_out), .frame_start(frame_start)
  );

  initial begin
    clk = 1'b0;
    forever #20 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Reference colour of one pixel, derived directly from the pattern definitions.
  function automatic logic [11:0] expectedPixel(input int h, input int v, input bit de,
                                                input bit scr, input logic [11:0] solid);
    int bar, off, code, lvl;
    if (!m_synced || !de || h >= 640 || v >= 480) return 12'h000;
    case (m_mode)
      0: begin
        bar  = h / (640 / 8);
        off  = scr ? (m_frames / 16) % 8 : 0;
        code = (bar + off) % 8;
        return {((code / 4) % 2 == 1) ? 4'hF : 4'h0,
                ((code / 2) % 2 == 1) ? 4'hF : 4'h0,
                (code % 2 == 1)       ? 4'hF : 4'h0};
      end
      1: return ((((h / 32) + (v / 32)) % 2) == 1) ? 12'hFFF : 12'h000;
      2: begin
        lvl = (h / 32) % 16;
        return {3{4'(lvl)}};
      end
      default: return solid;
    endcase
  endfunction

  task automatic applyStimulus(input bit rst, input int h, input int v, input bit de,
                               input logic [1:0] mode, input bit scr);
    bit          fs;
    logic [11:0] pix;
    reset      = rst;
    hpos       = 10'(h);
    vpos       = 10'(v);
    display_on = de;
    hsync_in   = 1'($urandom);
    vsync_in   = 1'($urandom);
    mode_req   = mode;
    scroll_en  = scr;
    solid_rgb  = 12'($urandom);
    @(posedge clk);
    if (rst) begin
      m_mode   = 0;
      m_frames = 0;
      m_synced = 0;
      pipe1    = '0;
      pipe2    = '0;
    end else begin
      fs = (h == 0 && v == 0);
      if (fs) begin
        m_mode   = int'(mode);
        m_frames = (m_frames + 1) % 256;
        m_synced = 1;
      end
      pix   = expectedPixel(h, v, de, scr, solid_rgb);
      pipe2 = pipe1;
      pipe1 = {pix, hsync_in, vsync_in, de, fs};
    end
    #1;
    dut_rgb = {VGA_R, VGA_G, VGA_B};
    checkOutput("rgb", {4'h0, dut_rgb}, {4'h0, pipe2[15:4]});
    checkOutput("hsync", {15'h0, VGA_HS}, {15'h0, pipe2[3]});
    checkOutput("vsync", {15'h0, VGA_VS}, {15'h0, pipe2[2]});
    checkOutput("de_out", {15'h0, de_out}, {15'h0, pipe2[1]});
    checkOutput("frame_start", {15'h0, frame_start}, {15'h0, pipe2[0]});
  endtask

  // Contiguous span of one line; mode_req is random except on the frame-start pixel.
  task automatic driveSpan(input int v, input int h0, input int h1, input logic [1:0] fs_mode,
                           input bit scr, input bit rst);
    for (int h = h0; h < h1; h++) begin
      applyStimulus(rst, h, v, ($urandom_range(0, 7) != 0),
                    (h == 0 && v == 0) ? fs_mode : 2'($urandom_range(0, 3)), scr);
    end
  endtask

  task automatic runFrame(input logic [1:0] fs_mode, input bit scr);
    for (int i = 0; i < 7; i++) driveSpan(frame_lines[i], 0, 800, fs_mode, scr, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 0, 0, 1'b0, 2'd0, 1'b0);
    checkOutput("reset_rgb", {4'h0, dut_rgb}, 16'h0000);

    runFrame(2'd0, 1'b0);

    driveSpan(5, 0, 300, 2'd0, 1'b0, 1'b0);
    driveSpan(5, 300, 303, 2'd0, 1'b0, 1'b1);
    checkOutput("midline_reset_rgb", {4'h0, dut_rgb}, 16'h0000);
    checkOutput("midline_reset_fs", {15'h0, frame_start}, 16'h0000);
    driveSpan(5, 303, 800, 2'd0, 1'b0, 1'b0);
    driveSpan(6, 0, 800, 2'd0, 1'b0, 1'b0);

    runFrame(2'd0, 1'b1);
    runFrame(2'd1, 1'b0);
    runFrame(2'd2, 1'b0);
    runFrame(2'd3, 1'b0);
    runFrame(2'd0, 1'b0);

    // Short frames from a fresh reset to walk the scroll offset through its checkpoints.
    for (int i = 0; i < 2; i++) applyStimulus(1'b1, 0, 0, 1'b0, 2'd0, 1'b0);
    for (int f = 1; f <= 130; f++) begin
      applyStimulus(1'b0, 0, 0, 1'b1, 2'd0, 1'b1);
      applyStimulus(1'b0, 1, 0, 1'b1, 2'($urandom_range(0, 3)), 1'b1);
      if (f == 15) checkOutput("scroll_f15_bar0", {4'h0, dut_rgb}, 16'h0000);
      if (f == 16) begin
        checkOutput("scroll_f16_bar0", {4'h0, dut_rgb}, 16'h000F);
        checkOutput("scroll_f16_fs", {15'h0, frame_start}, 16'h0001);
      end
      if (f == 32) checkOutput("scroll_f32_bar0", {4'h0, dut_rgb}, 16'h00F0);
      if (f == 128) checkOutput("scroll_f128_bar0", {4'h0, dut_rgb}, 16'h0000);
      applyStimulus(1'b0, 700, 500, 1'b1, 2'($urandom_range(0, 3)), 1'b1);
      applyStimulus(1'b0, 701, 500, 1'b1, 2'($urandom_range(0, 3)), 1'b1);
    end
    runFrame(2'd0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
